mem_burst_ctrl: RTL

- Bus master sitting directly upstream of the shared single-port memory (sel / w_en / tri-state address_bus and data_bus protocol).
- Accepts burst commands (base address, length, direction) and converts them into memory bus cycles.
- Streams write words in and read words out over valid/ready interfaces.
- Read path is fully pipelined against the memory's 1-cycle registered read, sustaining 1 word/cycle; a 2-entry output buffer absorbs backpressure.

---
 rtl/mem_burst_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst master for the shared single-port memory bus.
// Streams writes; pipelines reads into a 2-entry output FIFO.
module mem_burst_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int LEN_WIDTH     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_sel,
    output logic                     mem_w_en,
    inout  wire  [ADDRESS_WIDTH-1:0] address_bus,
    inout  wire  [DATA_WIDTH-1:0]    data_bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]     remaining;
    logic                     inflight;

    logic [DATA_WIDTH-1:0]    fifo [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;

    logic                     pop;
    logic                     issue;
    logic [2:0]               credit;

    assign pop    = rd_valid & rd_ready;
    // Slots already promised: buffered words plus the read in flight.
    assign credit = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue  = (state == RD) && (remaining != '0)
                    && (credit < 3'd2);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == TURN);
    assign wr_ready  = (state == WR);
    assign mem_w_en  = (state == WR);
    assign mem_sel   = (state == RD) || ((state == WR) && wr_valid);
    assign rd_valid  = (count != 2'd0);
    assign rd_data   = fifo[rd_ptr];

    assign address_bus = mem_sel ? addr : 'z;
    assign data_bus    = (mem_sel && mem_w_en) ? wr_data : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0)
                            state <= TURN;
                        else if (cmd_write)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        addr      <= addr + ADDRESS_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1))
                            state <= TURN;
                    end
                end
                RD: begin
                    inflight <= issue;
                    if (issue) begin
                        addr      <= addr + ADDRESS_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end else if (!inflight && remaining == '0) begin
                        state <= TURN;
                    end
                end
                TURN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (inflight)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (inflight)
            fifo[wr_ptr] <= data_bus;
    end

endmodule
